// File: rtl/sb_rx_pkg.sv
// Shared types and constants for the sideband receive deframer.
// Header layout: opcode in [4:0], control parity in [62], data parity in [63].
package sb_rx_pkg;

    localparam int unsigned WORD_W            = 64;
    localparam int unsigned PATTERN_COUNT_DEF = 2;

    localparam logic [WORD_W-1:0] PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;

    localparam logic [4:0] OPC_NO_DATA   = 5'b10010;
    localparam logic [4:0] OPC_WITH_DATA = 5'b11011;

    localparam int unsigned CP_BIT  = 62;
    localparam int unsigned DP_BIT  = 63;
    localparam int unsigned OPC_MSB = 4;
    localparam int unsigned OPC_LSB = 0;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_EMIT
    } rx_state_e;

endpackage

// File: rtl/sb_rx_deser.sv
// Sideband deserializer: packs valid UIs LSB-first into words and flags
// completed words and words cut short by a dropped bit-valid.
module sb_rx_deser #(
    parameter int unsigned WORD_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rxdatasb,
    input  logic              i_bit_valid,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_done,
    output logic              o_trunc,
    output logic              o_active
);

    localparam int unsigned CW = $clog2(WORD_W);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              done_q, done_d;
    logic              trunc_q, trunc_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        trunc_d = 1'b0;
        if (i_bit_valid) begin
            shift_d[cnt_q] = i_rxdatasb;
            if (cnt_q == CW'(WORD_W - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (cnt_q != '0) begin
            // A gap inside a word abandons it; gaps between words are free.
            cnt_d   = '0;
            trunc_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            trunc_q <= trunc_d;
        end
    end

    // Word stays intact during the done cycle: the next word starts at bit 0
    // and only overwrites it on the following edge.
    assign o_word      = shift_q;
    assign o_word_done = done_q;
    assign o_trunc     = trunc_q;
    assign o_active    = (cnt_q != '0);

endmodule

// File: rtl/sb_rx_deframer.sv
// Sideband RX deframer: init-pattern detection in SBINIT, otherwise header
// (+ optional data) message assembly with control/data parity checking.
module sb_rx_deframer
    import sb_rx_pkg::*;
#(
    parameter int unsigned PATTERN_COUNT = PATTERN_COUNT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rxdatasb,
    input  logic              i_bit_valid,
    input  logic              i_pattern_mode,
    output logic              o_pattern_detected,
    output logic [WORD_W-1:0] o_header,
    output logic [WORD_W-1:0] o_data,
    output logic              o_has_data,
    output logic              o_msg_valid,
    output logic              o_cp_err,
    output logic              o_dp_err,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int unsigned PCW = $clog2(PATTERN_COUNT + 1);

    logic [WORD_W-1:0] word;
    logic              word_done;
    logic              trunc;
    logic              deser_active;

    sb_rx_deser #(
        .WORD_W(WORD_W)
    ) u_deser (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rxdatasb  (i_rxdatasb),
        .i_bit_valid (i_bit_valid),
        .o_word      (word),
        .o_word_done (word_done),
        .o_trunc     (trunc),
        .o_active    (deser_active)
    );

    rx_state_e         state_q, state_d;
    logic [WORD_W-1:0] hdr_q, hdr_d;
    logic [WORD_W-1:0] out_hdr_q, out_hdr_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              has_data_q, has_data_d;
    logic [PCW-1:0]    pcnt_q, pcnt_d;
    logic              pat_q, pat_d;
    logic              ferr_q, ferr_d;
    logic              mode_q;

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        out_hdr_d  = out_hdr_q;
        out_data_d = out_data_q;
        has_data_d = has_data_q;
        pcnt_d     = pcnt_q;
        pat_d      = 1'b0;
        ferr_d     = 1'b0;

        if (i_pattern_mode != mode_q) begin
            pcnt_d  = '0;
            state_d = S_HDR;
        end else if (trunc) begin
            ferr_d  = 1'b1;
            pcnt_d  = '0;
            state_d = S_HDR;
        end else if (i_pattern_mode) begin
            state_d = S_HDR;
            if (word_done) begin
                if (word != PATTERN_WORD) begin
                    pcnt_d = '0;
                end else if (pcnt_q == PCW'(PATTERN_COUNT - 1)) begin
                    pat_d  = 1'b1;
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + PCW'(1);
                end
            end
        end else begin
            unique case (state_q)
                S_HDR: begin
                    if (word_done) begin
                        case (word[OPC_MSB:OPC_LSB])
                            OPC_NO_DATA: begin
                                out_hdr_d  = word;
                                out_data_d = '0;
                                has_data_d = 1'b0;
                                state_d    = S_EMIT;
                            end
                            OPC_WITH_DATA: begin
                                hdr_d   = word;
                                state_d = S_DATA;
                            end
                            default: ferr_d = 1'b1;
                        endcase
                    end
                end
                S_DATA: begin
                    if (word_done) begin
                        out_hdr_d  = hdr_q;
                        out_data_d = word;
                        has_data_d = 1'b1;
                        state_d    = S_EMIT;
                    end
                end
                S_EMIT:  state_d = S_HDR;
                default: state_d = S_HDR;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_HDR;
            hdr_q      <= '0;
            out_hdr_q  <= '0;
            out_data_q <= '0;
            has_data_q <= 1'b0;
            pcnt_q     <= '0;
            pat_q      <= 1'b0;
            ferr_q     <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            out_hdr_q  <= out_hdr_d;
            out_data_q <= out_data_d;
            has_data_q <= has_data_d;
            pcnt_q     <= pcnt_d;
            pat_q      <= pat_d;
            ferr_q     <= ferr_d;
            mode_q     <= i_pattern_mode;
        end
    end

    // Message outputs are registered on entry to S_EMIT and held afterwards;
    // the parity flags are derived from them and gated by the valid pulse.
    assign o_msg_valid        = (state_q == S_EMIT);
    assign o_header           = out_hdr_q;
    assign o_data             = out_data_q;
    assign o_has_data         = has_data_q;
    assign o_cp_err           = o_msg_valid & (out_hdr_q[CP_BIT] != ^out_hdr_q[CP_BIT-1:0]);
    assign o_dp_err           = o_msg_valid & has_data_q & (out_hdr_q[DP_BIT] != ^out_data_q);
    assign o_pattern_detected = pat_q;
    assign o_frame_err        = ferr_q;
    assign o_busy             = deser_active | (state_q != S_HDR);

endmodule

// File: tb/tb_sb_rx_deframer.sv
// Directed bench for sb_rx_deframer: table of messages plus hand-written
// pattern, truncation, overlap and reset sequences.
module tb_sb_rx_deframer;

    logic        clk;
    logic        rst_n;
    logic        rxd;
    logic        bit_valid;
    logic        pattern_mode;
    logic        pattern_detected;
    logic [63:0] header;
    logic [63:0] data;
    logic        has_data;
    logic        msg_valid;
    logic        cp_err;
    logic        dp_err;
    logic        frame_err;
    logic        busy;

    sb_rx_deframer #(.PATTERN_COUNT(2)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_rxdatasb         (rxd),
        .i_bit_valid        (bit_valid),
        .i_pattern_mode     (pattern_mode),
        .o_pattern_detected (pattern_detected),
        .o_header           (header),
        .o_data             (data),
        .o_has_data         (has_data),
        .o_msg_valid        (msg_valid),
        .o_cp_err           (cp_err),
        .o_dp_err           (dp_err),
        .o_frame_err        (frame_err),
        .o_busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hdr;
        logic        has_data;
        logic [63:0] data;
        logic        exp_cp;
        logic        exp_dp;
    } vec_t;

    vec_t vecs [8];

    int tests = 0;
    int fails = 0;
    int n_msg = 0;
    int n_pat = 0;
    int n_ferr = 0;

    always @(negedge clk) begin
        if (msg_valid)        n_msg++;
        if (pattern_detected) n_pat++;
        if (frame_err)        n_ferr++;
    end

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rxd       = b;
        bit_valid = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 64; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            rxd       = 1'b0;
        end
    endtask

    // Drops bit-valid after the last driven bit and returns the negedge index
    // at which the selected output is first seen high (99 if never).
    task automatic wait_out(input int sel, output int k);
        logic s;
        k = 99;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            rxd       = 1'b0;
            s = (sel == 0) ? msg_valid : (sel == 1) ? pattern_detected : frame_err;
            if (s) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic check_msg(input string tag, input vec_t v, input int k);
        logic [63:0] exp_data;
        exp_data = v.has_data ? v.data : 64'h0;
        check({tag, " latency"},  144'(k), 144'(2));
        check({tag, " header"},   144'(header), 144'(v.hdr));
        check({tag, " data"},     144'(data), 144'(exp_data));
        check({tag, " has_data"}, 144'(has_data), 144'(v.has_data));
        check({tag, " cp_err"},   144'(cp_err), 144'(v.exp_cp));
        check({tag, " dp_err"},   144'(dp_err), 144'(v.exp_dp));
    endtask

    initial begin
        int k;
        int m0, p0, f0;
        logic [63:0] pat;
        logic [63:0] brk;
        vec_t v;

        pat = 64'hAAAA_AAAA_AAAA_AAAA;
        brk = 64'hAAAA_AAAA_AAAA_AAAB;
        vecs[0] = '{64'h0000_0000_0000_0012, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[1] = '{64'h4000_0000_0000_0012, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h4000_1234_0000_0012, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[3] = '{64'h0000_0000_0000_001B, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
        vecs[4] = '{64'h0000_0000_0000_001B, 1'b1, 64'h0123_4567_89AB_CDEE, 1'b0, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_001B, 1'b1, 64'h0123_4567_89AB_CDEE, 1'b0, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_001B, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_0012, 1'b0, 64'h0, 1'b0, 1'b0};

        rst_n        = 1'b0;
        rxd          = 1'b0;
        bit_valid    = 1'b0;
        pattern_mode = 1'b0;
        #12;
        check("reset outputs",
              144'({pattern_detected, header, data, has_data, msg_valid, cp_err, dp_err, frame_err, busy}),
              144'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Pattern: two consecutive pattern words
        pattern_mode = 1'b1;
        idle(3);
        send_word(pat);
        send_word(pat);
        wait_out(1, k);
        check("pattern latency", 144'(k), 144'(2));
        idle(8);
        @(posedge clk);
        check("pattern pulses", 144'(n_pat), 144'(1));
        check("pattern no msg", 144'(n_msg), 144'(0));

        // Broken pattern: one good word, one bad, then two good
        p0 = n_pat;
        send_word(pat);
        send_word(brk);
        send_word(pat);
        send_word(pat);
        wait_out(1, k);
        check("broken pattern latency", 144'(k), 144'(2));
        idle(8);
        @(posedge clk);
        check("broken pattern pulses", 144'(n_pat - p0), 144'(1));

        pattern_mode = 1'b0;
        idle(3);

        // Message table
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            send_word(v.hdr);
            if (v.has_data) send_word(v.data);
            wait_out(0, k);
            check_msg($sformatf("vec%0d", i), v, k);
            idle(32);
        end
        @(posedge clk);
        check("msg count", 144'(n_msg), 144'(8));
        check("idle busy", 144'(busy), 144'(0));

        // Truncated data word, then a clean no-data message
        m0 = n_msg;
        f0 = n_ferr;
        send_word(64'h0000_0000_0000_001B);
        for (int i = 0; i < 40; i++) send_bit(1'b1);
        wait_out(2, k);
        check("trunc frame_err seen", 144'(k >= 1 && k <= 4), 144'(1));
        idle(8);
        @(posedge clk);
        check("trunc frame_err pulses", 144'(n_ferr - f0), 144'(1));
        check("trunc no msg", 144'(n_msg - m0), 144'(0));
        send_word(vecs[2].hdr);
        wait_out(0, k);
        check_msg("after trunc", vecs[2], k);
        idle(8);

        // Unsupported opcode
        f0 = n_ferr;
        m0 = n_msg;
        send_word(64'h0000_0000_0000_0000);
        wait_out(2, k);
        check("bad opc frame_err latency", 144'(k), 144'(2));
        idle(8);
        @(posedge clk);
        check("bad opc pulses", 144'(n_ferr - f0), 144'(1));
        check("bad opc no msg", 144'(n_msg - m0), 144'(0));

        // Back-to-back: second header starts while the first is emitted
        m0 = n_msg;
        send_word(vecs[0].hdr);
        send_word(vecs[2].hdr);
        wait_out(0, k);
        check_msg("overlap", vecs[2], k);
        idle(8);
        @(posedge clk);
        check("overlap msg count", 144'(n_msg - m0), 144'(2));

        // Asynchronous reset mid-word
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        @(posedge clk);
        #2;
        check("busy mid-word", 144'(busy), 144'(1));
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              144'({pattern_detected, header, data, has_data, msg_valid, cp_err, dp_err, frame_err, busy}),
              144'(0));
        @(negedge clk);
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_word(vecs[3].hdr);
        send_word(vecs[3].data);
        wait_out(0, k);
        check_msg("after reset", vecs[3], k);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
